mult_seq_ctrl: RTL and testbench

Sequencing controller for the 8-bit shift-add multiplier datapath built around the switch-loaded Q (multiplier), M (multiplicand) and A (accumulator) registers. It gates operand loads from the board switches, and on a start request it issues the clear / add / shift control pulses for one full multiplication. It flags completion to the display logic. The block holds only state and an iteration counter; all data registers live in the datapath.

---
 rtl/mult_seq_ctrl.sv | 101 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a shift-add multiplier: gates operand loads from the
// switches and issues one clear, then add/shift pulses per multiplier bit.
module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ldm,
    input  logic                       ldq,
    input  logic                       start,
    input  logic                       q0,
    output logic                       ld_m,
    output logic                       ld_q,
    output logic                       clr_a,
    output logic                       add_en,
    output logic                       shift_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] iter
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_start_q;
    logic          w_start_rise;
    logic [IW-1:0] r_iter;
    logic          r_clr_a;
    logic          r_add_en;
    logic          r_shift_en;
    logic          r_busy;
    logic          r_done;

    assign w_start_rise = start & ~r_start_q;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_rise) w_next = S_CLR;
            S_CLR:   w_next = S_TEST;
            S_TEST:  w_next = q0 ? S_ADD : S_SHIFT;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: w_next = (r_iter == LAST) ? S_DONE : S_TEST;
            // A fresh start takes priority over a load request when leaving DONE.
            S_DONE: begin
                if (w_start_rise)      w_next = S_CLR;
                else if (ldm || ldq)   w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_iter     <= '0;
            r_clr_a    <= 1'b0;
            r_add_en   <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_start_q  <= start;
            if (w_next == S_CLR)
                r_iter <= '0;
            else if (r_state == S_SHIFT)
                r_iter <= r_iter + IW'(1);
            r_clr_a    <= (w_next == S_CLR);
            r_add_en   <= (w_next == S_ADD);
            r_shift_en <= (w_next == S_SHIFT);
            r_busy     <= (w_next == S_CLR) || (w_next == S_TEST) ||
                          (w_next == S_ADD) || (w_next == S_SHIFT);
            r_done     <= (w_next == S_DONE);
        end
    end

    // Loads requested while busy are dropped, never queued.
    assign ld_m     = ldm & ~r_busy;
    assign ld_q     = ldq & ~r_busy;
    assign clr_a    = r_clr_a;
    assign add_en   = r_add_en;
    assign shift_en = r_shift_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign iter     = r_iter;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a behavioural datapath feeds q0, and a per-cycle expected
// trace built from the multiplier bits is compared against the controller outputs.
module tb_mult_seq_ctrl;

    localparam int W  = 8;
    localparam int IW = $clog2(W + 1);
    localparam int EW = 5 + IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ldm = 1'b0;
    logic          ldq = 1'b0;
    logic          start = 1'b0;
    logic          q0;
    logic          ld_m, ld_q, clr_a, add_en, shift_en, busy, done;
    logic [IW-1:0] iter;

    int n_checks = 0;
    int n_err    = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cmp_e;

    logic [W:0]    dp_a  = '0;
    logic [W-1:0]  dp_q  = '0;
    logic [W-1:0]  dp_m  = '0;
    logic [W-1:0]  sw_m  = '0;
    logic [W-1:0]  sw_q  = '0;
    logic          c_ldm = 1'b0, c_ldq = 1'b0, c_clr = 1'b0, c_add = 1'b0, c_shf = 1'b0;

    int            cnt_busy = 0, cnt_add = 0, cnt_shift = 0;
    logic          model_done = 1'b0;
    logic [IW-1:0] model_iter = '0;
    int            run_k;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ldm(ldm), .ldq(ldq), .start(start), .q0(q0),
        .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .add_en(add_en),
        .shift_en(shift_en), .busy(busy), .done(done), .iter(iter)
    );

    assign q0 = dp_q[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic b, input logic c, input logic a,
                                         input logic s, input logic d, input int it);
        return {b, c, a, s, d, IW'(it)};
    endfunction

    function automatic logic [EW-1:0] hold();
        return {1'b0, 1'b0, 1'b0, 1'b0, model_done, model_iter};
    endfunction

    // Scoreboard: one expected entry per cycle, compared away from the active edge.
    always @(negedge clk) begin
        c_ldm = ld_m; c_ldq = ld_q; c_clr = clr_a; c_add = add_en; c_shf = shift_en;
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            check("ctrl{busy,clr,add,shift,done,iter}",
                  32'({busy, clr_a, add_en, shift_en, done, iter}), 32'(cmp_e));
            check("ld_m", 32'(ld_m), 32'(ldm & ~cmp_e[EW-1]));
            check("ld_q", 32'(ld_q), 32'(ldq & ~cmp_e[EW-1]));
            cnt_busy  += int'(busy);
            cnt_add   += int'(add_en);
            cnt_shift += int'(shift_en);
        end
    end

    // Behavioural datapath with carry, driven by the controls captured last negedge.
    always @(posedge clk) begin
        if (c_ldm) dp_m <= sw_m;
        if (c_ldq) dp_q <= sw_q;
        if (c_clr)
            dp_a <= '0;
        else if (c_add)
            dp_a <= {1'b0, dp_a[W-1:0]} + {1'b0, dp_m};
        else if (c_shf)
            {dp_a, dp_q} <= {dp_a, dp_q} >> 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [EW-1:0] e);
        exp_q.push_back(e);
        tick();
    endtask

    task automatic busy_cyc(input logic [EW-1:0] e, input bit disturb);
        if (disturb) begin
            case (run_k)
                5:  start = 1'b0;
                10: begin ldm = 1'b1; ldq = 1'b1; start = 1'b1; sw_m = ~sw_m; sw_q = ~sw_q; end
                11: begin ldm = 1'b0; ldq = 1'b0; end
                default: ;
            endcase
        end
        cyc(e);
        run_k++;
    endtask

    task automatic run(input logic load, input logic [W-1:0] mq, input logic [W-1:0] mm,
                       input bit disturb, input int n_done);
        logic [W-1:0] mult, mcand;
        if (load) begin
            sw_q = mq; sw_m = mm; ldm = 1'b1; ldq = 1'b1; start = 1'b0;
            cyc(hold());
            model_done = 1'b0;
            ldm = 1'b0; ldq = 1'b0;
            mult = mq; mcand = mm;
        end else begin
            start = 1'b0;
            cyc(hold());
            mult = dp_q; mcand = dp_m;
        end
        cnt_busy = 0; cnt_add = 0; cnt_shift = 0;
        start = 1'b1;
        cyc(hold());
        run_k = 1;
        busy_cyc(mk(1, 1, 0, 0, 0, 0), disturb);
        for (int i = 0; i < W; i++) begin
            busy_cyc(mk(1, 0, 0, 0, 0, i), disturb);
            if (mult[i]) busy_cyc(mk(1, 0, 1, 0, 0, i), disturb);
            busy_cyc(mk(1, 0, 0, 1, 0, i), disturb);
        end
        model_done = 1'b1;
        model_iter = IW'(W);
        for (int j = 0; j < n_done; j++) cyc(hold());
        check("busy_cycles", 32'(cnt_busy), 32'(1 + 2 * W + $countones(mult)));
        check("add_pulses", 32'(cnt_add), 32'($countones(mult)));
        check("shift_pulses", 32'(cnt_shift), 32'(W));
        check("product", 32'({dp_a[W-1:0], dp_q}), 32'(mult) * 32'(mcand));
    endtask

    initial begin
        // Reset held three cycles with ldm high.
        rst = 1'b1; ldm = 1'b1; ldq = 1'b0; start = 1'b0;
        tick();
        repeat (3) cyc(mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0; ldm = 1'b0; ldq = 1'b1;
        cyc(hold());
        ldq = 1'b0;
        cyc(hold());

        run(1'b1, 8'hC3, 8'h05, 1'b0, 3);
        check("pin_busy_c3", 32'(cnt_busy), 32'd21);
        check("pin_add_c3", 32'(cnt_add), 32'd4);
        check("pin_shift_c3", 32'(cnt_shift), 32'd8);
        check("pin_prod_c3", 32'({dp_a[W-1:0], dp_q}), 32'h03CF);
        check("pin_iter_done", 32'(iter), 32'd8);

        run(1'b1, 8'h00, 8'hAB, 1'b0, 2);
        check("pin_busy_00", 32'(cnt_busy), 32'd17);
        check("pin_add_00", 32'(cnt_add), 32'd0);

        run(1'b1, 8'hFF, 8'hFF, 1'b0, 2);
        check("pin_busy_ff", 32'(cnt_busy), 32'd25);
        check("pin_prod_ff", 32'({dp_a[W-1:0], dp_q}), 32'hFE01);

        // Loads and a re-raised start during cycle 10 must be ignored.
        run(1'b1, 8'hC3, 8'h05, 1'b1, 3);
        check("pin_busy_dist", 32'(cnt_busy), 32'd21);
        check("pin_prod_dist", 32'({dp_a[W-1:0], dp_q}), 32'h03CF);

        // DONE left through ldq, start still high.
        ldq = 1'b1; sw_q = 8'h3C;
        cyc(hold());
        model_done = 1'b0;
        cyc(hold());
        ldq = 1'b0;
        cyc(hold());

        // DONE left through a fresh start edge; reruns with the operands in place.
        run(1'b1, 8'h5A, 8'h13, 1'b0, 1);
        run(1'b0, 8'h00, 8'h00, 1'b0, 2);

        // Reset during the first ADD cycle.
        sw_q = 8'h35; sw_m = 8'h0B; ldm = 1'b1; ldq = 1'b1; start = 1'b0;
        cyc(hold());
        model_done = 1'b0; ldm = 1'b0; ldq = 1'b0; start = 1'b1;
        cyc(hold());
        cyc(mk(1, 1, 0, 0, 0, 0));
        cyc(mk(1, 0, 0, 0, 0, 0));
        rst = 1'b1; start = 1'b0;
        cyc(mk(1, 0, 1, 0, 0, 0));
        model_iter = '0;
        rst = 1'b0;
        cnt_shift = 0;
        repeat (3) cyc(hold());
        check("no_shift_after_rst", 32'(cnt_shift), 32'd0);
        run(1'b1, 8'h35, 8'h0B, 1'b0, 2);

        for (int r = 0; r < 8; r++)
            run(1'b1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), $urandom_range(1, 3));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
